q2a03_bus_responder: RTL and testbench

CPU-bus target for the Q2A03 core. It sits on the far side of the `G_addr`/`G_rdwr`/`G_wr_data`/`G_rd_data`/`G_ready` bus and answers the accesses the CPU initiates. It serves:
- internal work RAM, mirrored;
- two serial joypad ports at $4016/$4017;
- a PRG window at $8000-$FFFF, forwarded over a request/acknowledge port with wait-state generation.

---
 rtl/q2a03_bus_responder.sv | 156 +++++++++++++++
 tb/tb_q2a03_bus_responder.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/q2a03_bus_responder.sv
// rtl/q2a03_bus_responder.sv - Q2A03 CPU-bus target: mirrored work RAM, joypads, PRG window
// Accesses are framed by G_phy2 edges; only PRG reads stall the CPU.
module q2a03_bus_responder #(
    parameter int RAM_ADDR_BITS = 11,
    parameter int EXT_TIMEOUT   = 16
) (
    input  logic        G_clock,
    input  logic        G_reset,
    input  logic        G_phy2,
    input  logic [15:0] G_addr,
    input  logic        G_rdwr,
    input  logic [7:0]  G_wr_data,
    output logic [7:0]  G_rd_data,
    output logic        G_ready,
    output logic        ext_req,
    output logic [14:0] ext_addr,
    input  logic [7:0]  ext_data,
    input  logic        ext_ack,
    input  logic [7:0]  pad0_buttons,
    input  logic [7:0]  pad1_buttons
);

    localparam int TW = $clog2(EXT_TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_RAM_RD, S_EXT_WAIT, S_HOLD} state_t;
    typedef enum logic [2:0] {SEL_NONE, SEL_RAM, SEL_PAD0, SEL_PAD1, SEL_PRG} sel_t;

    state_t                   r_state;
    sel_t                     r_sel;
    sel_t                     w_sel;
    logic                     r_phy2_q;
    logic                     r_rdwr;
    logic [RAM_ADDR_BITS-1:0] r_idx;
    logic [TW-1:0]            r_timer;
    logic [7:0]               r_rd_data;
    logic                     r_ready;
    logic                     r_ext_req;
    logic [14:0]              r_ext_addr;
    logic                     r_strobe;
    logic [7:0]               r_shift0;
    logic [7:0]               r_shift1;
    logic [7:0]               r_ram [0:(2**RAM_ADDR_BITS)-1];

    logic w_start;
    logic w_end;
    logic w_commit;
    logic w_ram_we;

    assign w_start  = G_phy2 & ~r_phy2_q;
    assign w_end    = ~G_phy2 & r_phy2_q;
    assign w_commit = (r_state == S_HOLD) && w_end;
    assign w_ram_we = !G_reset && w_commit && !r_rdwr && (r_sel == SEL_RAM);

    assign G_rd_data = r_rd_data;
    assign G_ready   = r_ready;
    assign ext_req   = r_ext_req;
    assign ext_addr  = r_ext_addr;

    // $4017 is only a pad port for reads; writing it is unmapped
    always_comb begin
        w_sel = SEL_NONE;
        if (G_addr[15:13] == 3'b000)
            w_sel = SEL_RAM;
        else if (G_addr[15])
            w_sel = SEL_PRG;
        else if (G_addr == 16'h4016)
            w_sel = SEL_PAD0;
        else if (G_addr == 16'h4017 && G_rdwr)
            w_sel = SEL_PAD1;
    end

    always_ff @(posedge G_clock) begin
        if (w_ram_we)
            r_ram[r_idx] <= G_wr_data;
    end

    always_ff @(posedge G_clock) begin
        if (G_reset) begin
            r_state    <= S_IDLE;
            r_sel      <= SEL_NONE;
            r_phy2_q   <= 1'b0;
            r_rdwr     <= 1'b1;
            r_idx      <= '0;
            r_timer    <= '0;
            r_rd_data  <= 8'h00;
            r_ready    <= 1'b1;
            r_ext_req  <= 1'b0;
            r_ext_addr <= 15'h0000;
            r_strobe   <= 1'b0;
            r_shift0   <= 8'h00;
            r_shift1   <= 8'h00;
        end else begin
            r_phy2_q <= G_phy2;
            unique case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_sel   <= w_sel;
                        r_rdwr  <= G_rdwr;
                        r_idx   <= G_addr[RAM_ADDR_BITS-1:0];
                        r_state <= S_HOLD;
                        if (G_rdwr) begin
                            case (w_sel)
                                SEL_RAM:  r_state <= S_RAM_RD;
                                SEL_PRG: begin
                                    r_state    <= S_EXT_WAIT;
                                    r_ext_req  <= 1'b1;
                                    r_ready    <= 1'b0;
                                    r_ext_addr <= G_addr[14:0];
                                    r_timer    <= '0;
                                end
                                SEL_PAD0: r_rd_data <= {7'b0100000, r_shift0[0]};
                                SEL_PAD1: r_rd_data <= {7'b0100000, r_shift1[0]};
                                default:  ;
                            endcase
                        end
                    end
                end
                S_RAM_RD: begin
                    r_rd_data <= r_ram[r_idx];
                    r_state   <= S_HOLD;
                end
                S_EXT_WAIT: begin
                    // an ack coinciding with the last timeout clock still delivers data
                    if (ext_ack || r_timer == TW'(EXT_TIMEOUT - 1)) begin
                        r_rd_data <= ext_ack ? ext_data : 8'hFF;
                        r_ext_req <= 1'b0;
                        r_ready   <= 1'b1;
                        r_state   <= S_HOLD;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                S_HOLD: begin
                    // level test so a fall swallowed during a stall still returns to idle
                    if (!G_phy2)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_commit && !r_rdwr && r_sel == SEL_PAD0)
                r_strobe <= G_wr_data[0];

            if (r_strobe) begin
                r_shift0 <= pad0_buttons;
                r_shift1 <= pad1_buttons;
            end else if (w_commit && r_rdwr) begin
                if (r_sel == SEL_PAD0)
                    r_shift0 <= {1'b1, r_shift0[7:1]};
                if (r_sel == SEL_PAD1)
                    r_shift1 <= {1'b1, r_shift1[7:1]};
            end
        end
    end

endmodule

// File: tb/tb_q2a03_bus_responder.sv
// tb/tb_q2a03_bus_responder.sv - directed scoreboard bench for q2a03_bus_responder
module tb_q2a03_bus_responder;

    logic        G_clock = 1'b0;
    logic        G_reset = 1'b1;
    logic        G_phy2 = 1'b0;
    logic [15:0] G_addr = 16'h0000;
    logic        G_rdwr = 1'b1;
    logic [7:0]  G_wr_data = 8'h00;
    logic [7:0]  G_rd_data;
    logic        G_ready;
    logic        ext_req;
    logic [14:0] ext_addr;
    logic [7:0]  ext_data = 8'h00;
    logic        ext_ack;
    logic [7:0]  pad0_buttons = 8'h00;
    logic [7:0]  pad1_buttons = 8'h00;

    logic        auto_ack = 1'b0;
    logic        force_ack = 1'b0;
    int          ack_delay = -1;
    int          req_cnt = 0;
    int          stall_total = 0;
    int          req_total = 0;
    logic [14:0] cap_addr = 15'h0000;
    int          n_tests = 0;
    int          n_fail = 0;
    logic [7:0]  exp_q[$];

    assign ext_ack = auto_ack | force_ack;

    q2a03_bus_responder dut (
        .G_clock      (G_clock),
        .G_reset      (G_reset),
        .G_phy2       (G_phy2),
        .G_addr       (G_addr),
        .G_rdwr       (G_rdwr),
        .G_wr_data    (G_wr_data),
        .G_rd_data    (G_rd_data),
        .G_ready      (G_ready),
        .ext_req      (ext_req),
        .ext_addr     (ext_addr),
        .ext_data     (ext_data),
        .ext_ack      (ext_ack),
        .pad0_buttons (pad0_buttons),
        .pad1_buttons (pad1_buttons)
    );

    always #5 G_clock = ~G_clock;

    // PRG responder: ack lands ack_delay clocks after ext_req first appears
    always @(negedge G_clock) begin
        auto_ack = 1'b0;
        if (ext_req) begin
            if (ack_delay > 0 && req_cnt == ack_delay - 1)
                auto_ack = 1'b1;
            req_cnt++;
        end else begin
            req_cnt = 0;
        end
    end

    always @(negedge G_clock) begin
        if (G_phy2 && !G_ready)
            stall_total++;
        if (ext_req) begin
            req_total++;
            cap_addr = ext_addr;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic access(input logic [15:0] a, input logic rw, input logic [7:0] wd,
                          output logic [7:0] rd, output int stalls, output int reqs);
        int s0;
        int r0;
        int budget;
        @(negedge G_clock);
        s0 = stall_total;
        r0 = req_total;
        G_addr = a;
        G_rdwr = rw;
        G_wr_data = wd;
        G_phy2 = 1'b1;
        repeat (6) @(negedge G_clock);
        budget = 64;
        while (!G_ready && budget > 0) begin
            @(negedge G_clock);
            budget--;
        end
        if (budget == 0)
            check("ready_release", {31'd0, G_ready}, 32'd1);
        rd = G_rd_data;
        stalls = stall_total - s0;
        reqs = req_total - r0;
        G_phy2 = 1'b0;
        repeat (5) @(negedge G_clock);
    endtask

    task automatic rd_chk(input string tag, input logic [15:0] a, input logic [7:0] exp, input int exp_stall);
        logic [7:0] d;
        int s;
        int r;
        exp_q.push_back(exp);
        access(a, 1'b1, 8'h00, d, s, r);
        check(tag, {24'd0, d}, {24'd0, exp_q.pop_front()});
        check({tag, "_stall"}, s, exp_stall);
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] v);
        logic [7:0] d;
        int s;
        int r;
        access(a, 1'b0, v, d, s, r);
        check("wr_no_stall", s, 0);
        check("wr_no_req", r, 0);
    endtask

    initial begin
        logic [9:0] seq;
        int budget;

        repeat (3) @(negedge G_clock);
        G_reset = 1'b0;
        @(negedge G_clock);
        check("rst_rd_data", {24'd0, G_rd_data}, 32'h00);
        check("rst_ready", {31'd0, G_ready}, 32'd1);
        check("rst_ext_req", {31'd0, ext_req}, 32'd0);
        check("rst_ext_addr", {17'd0, ext_addr}, 32'd0);

        rd_chk("pad0_after_reset", 16'h4016, 8'h40, 0);

        wr(16'h0005, 8'h5A);
        rd_chk("ram_mirror_0805", 16'h0805, 8'h5A, 0);
        rd_chk("ram_mirror_1805", 16'h1805, 8'h5A, 0);
        wr(16'h07FF, 8'h33);
        rd_chk("ram_top_17ff", 16'h17FF, 8'h33, 0);
        rd_chk("open_bus_5000", 16'h5000, 8'h33, 0);

        ack_delay = 5;
        ext_data = 8'hA9;
        rd_chk("prg_c123", 16'hC123, 8'hA9, 5);
        check("prg_ext_addr", {17'd0, cap_addr}, 32'h4123);

        ack_delay = -1;
        rd_chk("prg_timeout", 16'hFFFC, 8'hFF, 16);
        check("timeout_ext_addr", {17'd0, cap_addr}, 32'h7FFC);
        @(negedge G_clock);
        ext_data = 8'h12;
        force_ack = 1'b1;
        @(negedge G_clock);
        force_ack = 1'b0;
        @(negedge G_clock);
        check("late_ack_ignored", {24'd0, G_rd_data}, 32'hFF);
        check("late_ack_no_req", {31'd0, ext_req}, 32'd0);

        ack_delay = 16;
        ext_data = 8'h5C;
        rd_chk("ack_at_timeout", 16'h8000, 8'h5C, 16);
        ack_delay = -1;

        pad0_buttons = 8'h81;
        wr(16'h4016, 8'h01);
        wr(16'h4016, 8'h00);
        seq = 10'b1110000001;
        for (int i = 0; i < 10; i++)
            rd_chk($sformatf("pad0_read%0d", i), 16'h4016, {7'b0100000, seq[i]}, 0);

        wr(16'h4016, 8'h01);
        pad1_buttons = 8'h01;
        for (int i = 0; i < 3; i++)
            rd_chk($sformatf("pad1_strobe%0d", i), 16'h4017, 8'h41, 0);

        wr(16'h8000, 8'hAB);
        wr(16'h0010, 8'h11);

        @(negedge G_clock);
        G_addr = 16'h9000;
        G_rdwr = 1'b1;
        G_phy2 = 1'b1;
        budget = 8;
        while (!ext_req && budget > 0) begin
            @(negedge G_clock);
            budget--;
        end
        check("mid_stall_req_up", {31'd0, ext_req}, 32'd1);
        G_reset = 1'b1;
        G_phy2 = 1'b0;
        @(negedge G_clock);
        check("mid_stall_req_drop", {31'd0, ext_req}, 32'd0);
        check("mid_stall_ready", {31'd0, G_ready}, 32'd1);
        check("mid_stall_rd_data", {24'd0, G_rd_data}, 32'h00);
        G_reset = 1'b0;
        repeat (5) @(negedge G_clock);

        G_addr = 16'h0010;
        G_rdwr = 1'b0;
        G_wr_data = 8'h77;
        G_phy2 = 1'b1;
        repeat (3) @(negedge G_clock);
        G_reset = 1'b1;
        G_phy2 = 1'b0;
        @(negedge G_clock);
        G_reset = 1'b0;
        repeat (5) @(negedge G_clock);
        rd_chk("write_discarded", 16'h0010, 8'h11, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
